// File: rtl/hazard_stall_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the decode-stage hazard/stall controller:
//     - REG_ADDR_W      : register-file address width
//     - ST_*            : FSM state encodings (also exported on state_o)
//     - ctrl_word_t     : bundle of pipeline control outputs
//     - CTRL_*          : canned control words, including the NOP word
//                         loaded into IF/ID and ID/EX
//     - detect_load_use : load-use hazard term
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 3;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LSTALL = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_FREEZE = 2'd3;

    typedef struct packed {
        logic pc_write_en;
        logic ifid_write_en;
        logic ifid_flush;
        logic idex_bubble;
        logic freeze;
    } ctrl_word_t;

    // Normal flow: everything advances.
    localparam ctrl_word_t CTRL_RUN = '{pc_write_en: 1'b1, ifid_write_en: 1'b1,
                                        ifid_flush: 1'b0, idex_bubble: 1'b0, freeze: 1'b0};
    // Load-use: hold PC and IF/ID, push a bubble into EX.
    localparam ctrl_word_t CTRL_LSTALL = '{pc_write_en: 1'b0, ifid_write_en: 1'b0,
                                           ifid_flush: 1'b0, idex_bubble: 1'b1, freeze: 1'b0};
    // Taken branch: fetch from the target, squash the wrong-path instructions.
    localparam ctrl_word_t CTRL_FLUSH = '{pc_write_en: 1'b1, ifid_write_en: 1'b1,
                                          ifid_flush: 1'b1, idex_bubble: 1'b1, freeze: 1'b0};
    // Memory not ready: every pipeline register holds.
    localparam ctrl_word_t CTRL_FREEZE = '{pc_write_en: 1'b0, ifid_write_en: 1'b0,
                                           ifid_flush: 1'b0, idex_bubble: 1'b0, freeze: 1'b1};
    // NOP word: both IF/ID and ID/EX load a NOP, nothing advances.
    // Driven while reset is asserted.
    localparam ctrl_word_t CTRL_NOP = '{pc_write_en: 1'b0, ifid_write_en: 1'b0,
                                        ifid_flush: 1'b1, idex_bubble: 1'b1, freeze: 1'b0};

    // A load in EX whose destination is a source read by the instruction in ID.
    // With a hardwired zero register, writes to r0 never carry a value.
    function automatic logic detect_load_use(
        input logic [REG_ADDR_W-1:0] rs_addr,
        input logic [REG_ADDR_W-1:0] rt_addr,
        input logic                  rs_used,
        input logic                  rt_used,
        input logic [REG_ADDR_W-1:0] ex_write_addr,
        input logic                  ex_memread,
        input logic                  zero_hardwired
    );
        logic match;
        match = (rs_used && (rs_addr == ex_write_addr)) ||
                (rt_used && (rt_addr == ex_write_addr));
        if (zero_hardwired && (ex_write_addr == '0)) begin
            match = 1'b0;
        end
        return ex_memread && match;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_if
//   Bundle between the pipeline datapath (master) and the hazard/stall unit
//   (slave).
//   master drives : ID source addresses/use flags, EX destination/load flag,
//                   branch_taken_i, mem_ready_i
//   slave drives  : pc_write_en_o, ifid_write_en_o, ifid_flush_o,
//                   idex_bubble_o, freeze_o, state_o, stall_count_o
// -----------------------------------------------------------------------------
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs_addr_i;
    logic [REG_ADDR_W-1:0] id_rt_addr_i;
    logic                  id_rs_used_i;
    logic                  id_rt_used_i;
    logic [REG_ADDR_W-1:0] ex_write_addr_i;
    logic                  ex_memread_i;
    logic                  branch_taken_i;
    logic                  mem_ready_i;

    logic                  pc_write_en_o;
    logic                  ifid_write_en_o;
    logic                  ifid_flush_o;
    logic                  idex_bubble_o;
    logic                  freeze_o;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_count_o;

    modport master (
        output id_rs_addr_i, id_rt_addr_i, id_rs_used_i, id_rt_used_i,
               ex_write_addr_i, ex_memread_i, branch_taken_i, mem_ready_i,
        input  pc_write_en_o, ifid_write_en_o, ifid_flush_o, idex_bubble_o,
               freeze_o, state_o, stall_count_o
    );

    modport slave (
        input  id_rs_addr_i, id_rt_addr_i, id_rs_used_i, id_rt_used_i,
               ex_write_addr_i, ex_memread_i, branch_taken_i, mem_ready_i,
        output pc_write_en_o, ifid_write_en_o, ifid_flush_o, idex_bubble_o,
               freeze_o, state_o, stall_count_o
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low clear
//   en_i    : count this cycle
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_reg <= '0;
        end else if (en_i && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//   Decode-stage controller for hazards that forwarding cannot cover:
//   load-use bubbles, multi-cycle taken-branch flushes and memory-not-ready
//   freezes. Control outputs respond combinationally in the same cycle; the
//   FSM state, saved return state and flush counter are registered.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : hazard_stall_unit_if.slave (hazard inputs, control outputs,
//             state_o, stall_count_o)
// -----------------------------------------------------------------------------
module hazard_stall_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter bit ZERO_REG_HARDWIRED  = 1'b1,
    parameter int CNT_W               = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    hazard_stall_unit_if.slave bus
);

    // The branch cycle itself is the first flush cycle and the FLUSH state
    // runs until the counter has been seen at zero, hence the "-2".
    localparam logic [2:0] FLUSH_RELOAD =
        (BRANCH_FLUSH_CYCLES > 1) ? 3'(BRANCH_FLUSH_CYCLES - 2) : 3'd0;

    logic [1:0] state_reg, state_next;
    logic [1:0] ret_state_reg, ret_state_next;
    logic [2:0] flush_cnt_reg, flush_cnt_next;
    logic [1:0] eff_state;
    logic       load_use;
    ctrl_word_t ctrl;
    ctrl_word_t ctrl_out;
    logic [CNT_W-1:0] stall_count;

    assign load_use = detect_load_use(bus.id_rs_addr_i, bus.id_rt_addr_i,
                                      bus.id_rs_used_i, bus.id_rt_used_i,
                                      bus.ex_write_addr_i, bus.ex_memread_i,
                                      ZERO_REG_HARDWIRED);

    // A FREEZE with memory ready behaves exactly like the state it
    // interrupted, so evaluate everything against the effective state.
    assign eff_state = (state_reg == ST_FREEZE) ? ret_state_reg : state_reg;

    always_comb begin
        ctrl           = CTRL_RUN;
        state_next     = ST_RUN;
        ret_state_next = ret_state_reg;
        flush_cnt_next = flush_cnt_reg;

        if (!bus.mem_ready_i) begin
            ctrl       = CTRL_FREEZE;
            state_next = ST_FREEZE;
            // LSTALL is one cycle and always continues into RUN, so only a
            // pending flush needs remembering. Inside FREEZE this reproduces
            // the held return state.
            ret_state_next = (eff_state == ST_FLUSH) ? ST_FLUSH : ST_RUN;
        end else if (bus.branch_taken_i) begin
            ctrl = CTRL_FLUSH;
            if (BRANCH_FLUSH_CYCLES > 1) begin
                state_next     = ST_FLUSH;
                flush_cnt_next = FLUSH_RELOAD;
            end
        end else if (eff_state == ST_FLUSH) begin
            // The ID instruction is being squashed; load_use is irrelevant.
            ctrl = CTRL_FLUSH;
            if (flush_cnt_reg != 3'd0) begin
                state_next     = ST_FLUSH;
                flush_cnt_next = flush_cnt_reg - 3'd1;
            end
        end else if ((eff_state == ST_RUN) && load_use) begin
            // In LSTALL the EX stage holds the bubble, so no re-detection.
            ctrl       = CTRL_LSTALL;
            state_next = ST_LSTALL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_RUN;
            ret_state_reg <= ST_RUN;
            flush_cnt_reg <= 3'd0;
        end else begin
            state_reg     <= state_next;
            ret_state_reg <= ret_state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Reset forces the NOP word so nothing advances while the core is held.
    assign ctrl_out = rst_n_i ? ctrl : CTRL_NOP;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (!ctrl_out.pc_write_en),
        .count_o (stall_count)
    );

    assign bus.pc_write_en_o   = ctrl_out.pc_write_en;
    assign bus.ifid_write_en_o = ctrl_out.ifid_write_en;
    assign bus.ifid_flush_o    = ctrl_out.ifid_flush;
    assign bus.idex_bubble_o   = ctrl_out.idex_bubble;
    assign bus.freeze_o        = ctrl_out.freeze;
    assign bus.state_o         = state_reg;
    assign bus.stall_count_o   = stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//   Directed bench for hazard_stall_unit. Two instances share one stimulus:
//     dut_a : defaults (2-cycle flush, zero register hardwired, 16-bit count)
//     dut_b : zero register not hardwired, 2-bit stall counter
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst_n;
    logic [2:0] rs, rt, ex_wr;
    logic       rs_used, rt_used, memread, br, mr;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit_if #(.CNT_W(16)) if_a ();
    hazard_stall_unit_if #(.CNT_W(2))  if_b ();

    assign if_a.id_rs_addr_i    = rs;
    assign if_a.id_rt_addr_i    = rt;
    assign if_a.id_rs_used_i    = rs_used;
    assign if_a.id_rt_used_i    = rt_used;
    assign if_a.ex_write_addr_i = ex_wr;
    assign if_a.ex_memread_i    = memread;
    assign if_a.branch_taken_i  = br;
    assign if_a.mem_ready_i     = mr;

    assign if_b.id_rs_addr_i    = rs;
    assign if_b.id_rt_addr_i    = rt;
    assign if_b.id_rs_used_i    = rs_used;
    assign if_b.id_rt_used_i    = rt_used;
    assign if_b.ex_write_addr_i = ex_wr;
    assign if_b.ex_memread_i    = memread;
    assign if_b.branch_taken_i  = br;
    assign if_b.mem_ready_i     = mr;

    hazard_stall_unit #(
        .BRANCH_FLUSH_CYCLES (2),
        .ZERO_REG_HARDWIRED  (1'b1),
        .CNT_W               (16)
    ) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (if_a.slave)
    );

    hazard_stall_unit #(
        .BRANCH_FLUSH_CYCLES (2),
        .ZERO_REG_HARDWIRED  (1'b0),
        .CNT_W               (2)
    ) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rs = 3'd0; rt = 3'd0; ex_wr = 3'd0;
        rs_used = 1'b0; rt_used = 1'b0; memread = 1'b0; br = 1'b0; mr = 1'b1;

        // ---- reset state ----
        #1;
        check("rst_pc",     32'(if_a.pc_write_en_o),   32'd0);
        check("rst_ifid",   32'(if_a.ifid_write_en_o), 32'd0);
        check("rst_flush",  32'(if_a.ifid_flush_o),    32'd1);
        check("rst_bubble", 32'(if_a.idex_bubble_o),   32'd1);
        check("rst_freeze", 32'(if_a.freeze_o),        32'd0);
        check("rst_state",  32'(if_a.state_o),         32'd0);
        check("rst_count",  32'(if_a.stall_count_o),   32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        check("run_pc",    32'(if_a.pc_write_en_o), 32'd1);
        check("run_count", 32'(if_a.stall_count_o), 32'd0);
        $display("txn reset: done");

        // ---- load-use via rt ----
        rt = 3'd3; rt_used = 1'b1; ex_wr = 3'd3; memread = 1'b1;
        #1;
        check("lu_pc",     32'(if_a.pc_write_en_o),   32'd0);
        check("lu_ifid",   32'(if_a.ifid_write_en_o), 32'd0);
        check("lu_bubble", 32'(if_a.idex_bubble_o),   32'd1);
        step();
        memread = 1'b0;
        #1;
        check("lu_state1", 32'(if_a.state_o),         32'd1);
        check("lu_pc2",    32'(if_a.pc_write_en_o),   32'd1);
        check("lu_ifid2",  32'(if_a.ifid_write_en_o), 32'd1);
        check("lu_bub2",   32'(if_a.idex_bubble_o),   32'd0);
        check("lu_count",  32'(if_a.stall_count_o),   32'd1);
        step();
        check("lu_state0", 32'(if_a.state_o), 32'd0);
        $display("txn load_use_rt: count_a=%0d", if_a.stall_count_o);

        // ---- rs path: unused source never stalls, used source does ----
        rt_used = 1'b0; rs = 3'd5; rs_used = 1'b0; ex_wr = 3'd5; memread = 1'b1;
        #1;
        check("rs_unused_pc", 32'(if_a.pc_write_en_o), 32'd1);
        rs_used = 1'b1;
        #1;
        check("rs_used_pc", 32'(if_a.pc_write_en_o), 32'd0);
        step();
        memread = 1'b0;
        step();
        check("rs_count", 32'(if_a.stall_count_o), 32'd2);
        rs_used = 1'b0;
        $display("txn load_use_rs: count_a=%0d", if_a.stall_count_o);

        // ---- zero register ----
        rt = 3'd0; rt_used = 1'b1; ex_wr = 3'd0; memread = 1'b1;
        #1;
        check("zr_hw_pc",   32'(if_a.pc_write_en_o), 32'd1);
        check("zr_nohw_pc", 32'(if_b.pc_write_en_o), 32'd0);
        step();
        check("zr_hw_state",   32'(if_a.state_o),       32'd0);
        check("zr_nohw_state", 32'(if_b.state_o),       32'd1);
        check("zr_hw_count",   32'(if_a.stall_count_o), 32'd2);
        check("zr_nohw_count", 32'(if_b.stall_count_o), 32'd3);
        memread = 1'b0;
        step();
        $display("txn zero_reg: count_a=%0d count_b=%0d", if_a.stall_count_o, if_b.stall_count_o);

        // ---- taken branch, default 2-cycle flush ----
        br = 1'b1;
        #1;
        check("br_flush0", 32'(if_a.ifid_flush_o),  32'd1);
        check("br_bub0",   32'(if_a.idex_bubble_o), 32'd1);
        check("br_pc0",    32'(if_a.pc_write_en_o), 32'd1);
        step();
        br = 1'b0;
        #1;
        check("br_state1", 32'(if_a.state_o),       32'd2);
        check("br_flush1", 32'(if_a.ifid_flush_o),  32'd1);
        check("br_bub1",   32'(if_a.idex_bubble_o), 32'd1);
        check("br_pc1",    32'(if_a.pc_write_en_o), 32'd1);
        step();
        check("br_state2", 32'(if_a.state_o),       32'd0);
        check("br_flush2", 32'(if_a.ifid_flush_o),  32'd0);
        check("br_bub2",   32'(if_a.idex_bubble_o), 32'd0);
        $display("txn branch: state_a=%0d", if_a.state_o);

        // ---- branch beats load-use ----
        rt = 3'd3; ex_wr = 3'd3; memread = 1'b1; br = 1'b1;
        #1;
        check("pri_pc",    32'(if_a.pc_write_en_o), 32'd1);
        check("pri_flush", 32'(if_a.ifid_flush_o),  32'd1);
        step();
        br = 1'b0; memread = 1'b0;
        #1;
        check("pri_state", 32'(if_a.state_o),       32'd2);
        check("pri_count", 32'(if_a.stall_count_o), 32'd2);
        step();
        check("pri_state2", 32'(if_a.state_o), 32'd0);
        $display("txn branch_priority: count_a=%0d", if_a.stall_count_o);

        // ---- freeze mid-flush ----
        br = 1'b1;
        #1;
        step();
        br = 1'b0; mr = 1'b0;
        #1;
        check("fz_freeze1", 32'(if_a.freeze_o),      32'd1);
        check("fz_pc1",     32'(if_a.pc_write_en_o), 32'd0);
        check("fz_flush1",  32'(if_a.ifid_flush_o),  32'd0);
        check("fz_state1",  32'(if_a.state_o),       32'd2);
        step();
        check("fz_freeze2", 32'(if_a.freeze_o),      32'd1);
        check("fz_state2",  32'(if_a.state_o),       32'd3);
        check("fz_satb",    32'(if_b.stall_count_o), 32'd3);
        step();
        check("fz_freeze3", 32'(if_a.freeze_o),      32'd1);
        check("fz_satb2",   32'(if_b.stall_count_o), 32'd3);
        step();
        mr = 1'b1;
        #1;
        check("fz_count",   32'(if_a.stall_count_o), 32'd5);
        check("fz_res_fz",  32'(if_a.freeze_o),      32'd0);
        check("fz_res_fl",  32'(if_a.ifid_flush_o),  32'd1);
        check("fz_res_bub", 32'(if_a.idex_bubble_o), 32'd1);
        check("fz_res_pc",  32'(if_a.pc_write_en_o), 32'd1);
        step();
        check("fz_done_state", 32'(if_a.state_o),      32'd0);
        check("fz_done_flush", 32'(if_a.ifid_flush_o), 32'd0);
        check("fz_done_count", 32'(if_a.stall_count_o), 32'd5);
        $display("txn freeze_mid_flush: count_a=%0d count_b=%0d", if_a.stall_count_o, if_b.stall_count_o);

        // ---- asynchronous reset mid-flush ----
        br = 1'b1;
        #1;
        step();
        br = 1'b0;
        #1;
        check("ar_pre_state", 32'(if_a.state_o), 32'd2);
        rst_n = 1'b0;
        #1;
        check("ar_state", 32'(if_a.state_o),       32'd0);
        check("ar_count", 32'(if_a.stall_count_o), 32'd0);
        check("ar_pc",    32'(if_a.pc_write_en_o), 32'd0);
        check("ar_flush", 32'(if_a.ifid_flush_o),  32'd1);
        step();
        rst_n = 1'b1;
        #1;
        check("ar_rel_state", 32'(if_a.state_o),       32'd0);
        check("ar_rel_pc",    32'(if_a.pc_write_en_o), 32'd1);
        $display("txn async_reset: state_a=%0d count_a=%0d", if_a.state_o, if_a.stall_count_o);

        // ---- saturation: five load-use stalls ----
        rt = 3'd3; rt_used = 1'b1; ex_wr = 3'd3;
        for (int i = 0; i < 5; i++) begin
            memread = 1'b1;
            step();
            memread = 1'b0;
            step();
        end
        check("sat_count_b", 32'(if_b.stall_count_o), 32'd3);
        check("sat_count_a", 32'(if_a.stall_count_o), 32'd5);
        $display("txn saturation: count_a=%0d count_b=%0d", if_a.stall_count_o, if_b.stall_count_o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline control block in the decode stage, directly upstream of the EX/WB operand forwarding logic.
- Covers the hazards forwarding cannot resolve:
  - load-use: inserts a one-cycle bubble so the loaded value reaches WB before the consumer enters EX, where forwarding then supplies it.
  - taken-branch flush: multi-cycle.
  - memory-not-ready freeze.
- Drives the PC enable, the IF/ID enable/flush and the ID/EX bubble, and keeps a saturating stall-cycle counter.

Parameters:
BRANCH_FLUSH_CYCLES, 2, total cycles of IF/ID flush plus ID/EX bubble per taken branch (legal 1..7)
ZERO_REG_HARDWIRED, 1, when 1 a destination address 3'd0 never creates a load-use hazard
CNT_W, 16, width of stall_count_o

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
id_rs_addr_i  input  3  rs of instruction in ID
id_rt_addr_i  input  3  rt of instruction in ID
id_rs_used_i  input  1  ID instruction reads rs
id_rt_used_i  input  1  ID instruction reads rt
ex_write_addr_i  input  3  destination of instruction in EX
ex_memread_i  input  1  EX instruction is a load
branch_taken_i  input  1  branch resolved taken in EX (single-cycle pulse)
mem_ready_i  input  1  data memory ready; 0 freezes pipeline
pc_write_en_o  output  1  PC may update
ifid_write_en_o  output  1  IF/ID register may update
ifid_flush_o  output  1  IF/ID loads NOP
idex_bubble_o  output  1  ID/EX loads NOP (control zeroed)
freeze_o  output  1  all pipeline registers hold
state_o  output  2  current FSM state (RUN=0, LSTALL=1, FLUSH=2, FREEZE=3)
stall_count_o  output  CNT_W  saturating count of cycles with pc_write_en_o=0

Behaviour:
- Load-use term: load_use = ex_memread_i & ((id_rs_used_i & rs==ex_write_addr_i) | (id_rt_used_i & rt==ex_write_addr_i)), forced to 0 when ZERO_REG_HARDWIRED=1 and ex_write_addr_i==0.
- FSM state and the 3-bit flush counter are registered. Control outputs are combinational from state plus inputs (same-cycle response).
- Reset (rst_n_i=0, asynchronous): state=RUN, flush counter=0, stall_count_o=0. While reset is asserted, outputs are forced to:
  - pc_write_en_o=0, ifid_write_en_o=0
  - ifid_flush_o=1, idex_bubble_o=1
  - freeze_o=0
- Priority in every state: mem_ready_i=0 first, then branch_taken_i, then load_use.
- RUN:
  - Default outputs: pc_write_en_o=1, ifid_write_en_o=1, all other controls 0.
  - mem_ready_i=0: freeze_o=1, pc/ifid enables 0, no bubble; next state FREEZE. Remember return state RUN.
  - branch_taken_i: ifid_flush_o=1, idex_bubble_o=1, pc_write_en_o=1.
    - BRANCH_FLUSH_CYCLES>1: next state FLUSH, counter=BRANCH_FLUSH_CYCLES-2.
    - BRANCH_FLUSH_CYCLES=1: stay in RUN.
  - load_use: pc_write_en_o=0, ifid_write_en_o=0, idex_bubble_o=1; next state LSTALL.
- LSTALL (exactly one cycle; EX now holds the bubble, so no re-detection):
  - Outputs as RUN.
  - branch_taken_i is handled as in RUN. The load itself cannot branch, so this is defensive.
  - Next state RUN, unless mem_ready_i=0, which goes to FREEZE.
- FLUSH:
  - ifid_flush_o=1, idex_bubble_o=1, pc_write_en_o=1.
  - Counter decrements each cycle; at counter==0 the next state is RUN.
  - load_use is ignored because the ID instruction is being flushed.
  - A new branch_taken_i reloads the counter to BRANCH_FLUSH_CYCLES-2.
- FREEZE:
  - freeze_o=1, pc_write_en_o=0, ifid_write_en_o=0, bubble/flush 0.
  - Saved return state and counter are held.
  - On mem_ready_i=1, return to the saved state, evaluated that same cycle with normal outputs.
  - branch_taken_i and load_use are ignored while frozen; upstream holds them stable.
- stall_count_o: increments on each clock edge where pc_write_en_o=0 and rst_n_i=1; saturates at all-ones (no wrap).
- Mid-operation reset returns to RUN immediately, discarding any pending flush count or freeze.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding constants (RUN/LSTALL/FLUSH/FREEZE)
  - REG_ADDR_W=3
  - NOP control-word constant used by IF/ID and ID/EX
- One sub-module is natural: sat_counter (parameterised width, enable, async active-low clear), used for stall_count_o.

Test Plan:
- Load-use, one cycle: ex_memread_i=1, ex_write_addr_i=3, id_rt_addr_i=3, id_rt_used_i=1.
  - Same cycle: pc_write_en_o=0, idex_bubble_o=1, state_o→1.
  - Next cycle with ex_memread_i=0: enables=1, state_o=0.
  - stall_count_o=1.
- Zero register: the same load-use stimulus with ex_write_addr_i=0 and ZERO_REG_HARDWIRED=1 → no stall.
  - With ZERO_REG_HARDWIRED=0 → stall.
- Taken branch, default flush: branch_taken_i pulse for 1 cycle → ifid_flush_o=1 and idex_bubble_o=1 for exactly 2 cycles, pc_write_en_o=1 throughout, state_o RUN→FLUSH→RUN.
- Branch priority: branch_taken_i and load_use in the same cycle → flush path taken; pc_write_en_o=1; stall_count_o unchanged.
- Freeze mid-flush: mem_ready_i=0 for 3 cycles during FLUSH.
  - freeze_o=1 for 3 cycles, stall_count_o +3.
  - On resume, the remaining flush cycle completes, then RUN.
- Reset and saturation:
  - CNT_W=2 with 5 load-use stalls → stall_count_o=3.
  - Asserting rst_n_i mid-FLUSH → state_o=0 and stall_count_o=0 asynchronously, before the next clock edge.
